// File: rtl/ysyx_22041211_sram_pkg.sv
// rtl/ysyx_22041211_sram_pkg.sv - shared constants and FSM encoding for the SRAM responder
package ysyx_22041211_sram_pkg;

    typedef enum logic [1:0] {
        SRAM_IDLE = 2'd0,
        SRAM_BUSY = 2'd1,
        SRAM_RESP = 2'd2
    } sram_state_e;

    localparam logic [3:0]  MASK_BYTE = 4'b0001;
    localparam logic [3:0]  MASK_HALF = 4'b0011;
    localparam logic [3:0]  MASK_WORD = 4'b1111;

    localparam logic [31:0] SRAM_ADDR_BASE = 32'h8000_0000;

endpackage

// File: rtl/ysyx_22041211_sram_array.sv
// rtl/ysyx_22041211_sram_array.sv - word array with byte-masked synchronous write and combinational read
module ysyx_22041211_sram_array
    import ysyx_22041211_sram_pkg::*;
#(
    parameter int DATA_LEN    = 32,
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [IDX_W-1:0]    idx,
    input  logic [3:0]          wmask,
    input  logic [DATA_LEN-1:0] wdata,
    output logic [DATA_LEN-1:0] rdata
);

    logic [DATA_LEN-1:0] mem [DEPTH_WORDS];

    // Byte-lane write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we && wmask[k]) begin
                mem[idx][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/ysyx_22041211_sram.sv
// rtl/ysyx_22041211_sram.sv - latency-configurable data-memory responder with fault reporting
module ysyx_22041211_sram
    import ysyx_22041211_sram_pkg::*;
#(
    parameter int                 DATA_LEN    = 32,
    parameter logic [DATA_LEN-1:0] ADDR_BASE  = SRAM_ADDR_BASE,
    parameter int                 DEPTH_WORDS = 1024,
    parameter int                 LATENCY     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_wen_i,
    input  logic [DATA_LEN-1:0] req_addr_i,
    input  logic [DATA_LEN-1:0] req_wdata_i,
    input  logic [3:0]          req_wmask_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_LEN-1:0] rsp_rdata_o,
    output logic                rsp_err_o
);

    localparam int                  IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [DATA_LEN-1:0] SPAN     = DATA_LEN'(4 * DEPTH_WORDS);
    localparam logic [3:0]          CNT_LOAD = 4'(LATENCY - 1);
    localparam bool_single = 1'b0;

    sram_state_e         state_q, state_d;
    logic [3:0]          cnt_q;
    logic                wen_q;
    logic [DATA_LEN-1:0] addr_q, wdata_q;
    logic [3:0]          wmask_q;
    logic [DATA_LEN-1:0] rdata_q;
    logic                err_q;

    logic                accept, access, fault, arr_we;
    logic                acc_wen;
    logic [DATA_LEN-1:0] acc_addr, acc_wdata, acc_off, arr_rdata;
    logic [3:0]          acc_wmask;

    assign accept = (state_q == SRAM_IDLE) && req_valid_i;

    // The access happens on the edge where the countdown expires; with a
    // single-cycle latency that is the acceptance edge itself, so the live
    // request fields are used instead of the latched copies.
    assign access = (accept && (LATENCY == 1))
                 || ((state_q == SRAM_BUSY) && (cnt_q <= 4'd1));

    assign acc_wen   = (state_q == SRAM_IDLE) ? req_wen_i   : wen_q;
    assign acc_addr  = (state_q == SRAM_IDLE) ? req_addr_i  : addr_q;
    assign acc_wdata = (state_q == SRAM_IDLE) ? req_wdata_i : wdata_q;
    assign acc_wmask = (state_q == SRAM_IDLE) ? req_wmask_i : wmask_q;

    // Unsigned offset wraps for addresses below the base, so one compare covers both ends.
    assign acc_off = acc_addr - ADDR_BASE;
    assign fault   = (acc_off >= SPAN) || (acc_addr[1:0] != 2'b00);
    // Gated by rst so a request presented during reset can never reach the array.
    assign arr_we  = access && acc_wen && !fault && !rst;

    ysyx_22041211_sram_array #(
        .DATA_LEN    (DATA_LEN),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .idx   (acc_off[IDX_W+1:2]),
        .wmask (acc_wmask),
        .wdata (acc_wdata),
        .rdata (arr_rdata)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= SRAM_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SRAM_IDLE: if (req_valid_i) state_d = (LATENCY == 1) ? SRAM_RESP : SRAM_BUSY;
            SRAM_BUSY: if (access)      state_d = SRAM_RESP;
            SRAM_RESP: if (rsp_ready_i) state_d = SRAM_IDLE;
            default:                    state_d = SRAM_IDLE;
        endcase
    end

    // Request capture and latency countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 4'd0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= 4'd0;
        end else if (accept) begin
            cnt_q   <= CNT_LOAD;
            wen_q   <= req_wen_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            wmask_q <= req_wmask_i;
        end else if ((state_q == SRAM_BUSY) && (cnt_q != 4'd0)) begin
            cnt_q   <= cnt_q - 4'd1;
        end
    end

    // Response registers, loaded only on the access edge so they stay stable in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (access) begin
            err_q   <= fault;
            rdata_q <= (fault || acc_wen) ? '0 : arr_rdata;
        end
    end

    assign req_ready_o = (state_q == SRAM_IDLE);
    assign rsp_valid_o = (state_q == SRAM_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_ysyx_22041211_sram.sv
// tb/tb_ysyx_22041211_sram.sv - scoreboard bench for the SRAM responder at latencies 2, 1 and 4
module tb_ysyx_22041211_sram;

    localparam int LAT_TAB [3] = '{2, 1, 4};

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic [2:0]  rst = 3'b000;
    logic        req_valid = 1'b0, req_wen = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wmask = '0;

    logic        rdy_v [3];
    logic        vld_v [3];
    logic        err_v [3];
    logic [31:0] rdata_v [3];

    int          sel = 0;
    logic        rdy, vld, err;
    logic [31:0] rdata;

    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ysyx_22041211_sram #(
            .LATENCY (LAT_TAB[g])
        ) u_dut (
            .clk         (clk),
            .rst         (rst[g]),
            .req_valid_i (req_valid),
            .req_ready_o (rdy_v[g]),
            .req_wen_i   (req_wen),
            .req_addr_i  (req_addr),
            .req_wdata_i (req_wdata),
            .req_wmask_i (req_wmask),
            .rsp_valid_o (vld_v[g]),
            .rsp_ready_i (rsp_ready),
            .rsp_rdata_o (rdata_v[g]),
            .rsp_err_o   (err_v[g])
        );
    end

    assign rdy   = rdy_v[sel];
    assign vld   = vld_v[sel];
    assign err   = err_v[sel];
    assign rdata = rdata_v[sel];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; hold > 0 stalls the response and offers a competing read meanwhile.
    task automatic txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, input logic [31:0] e_rdata, input logic e_err,
                       input int hold);
        int   n;
        exp_t e;
        sb.push_back('{rdata: e_rdata, err: e_err});
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = mask;
        n = 0;
        while (!rdy && n < 50) begin
            step();
            n++;
        end
        chk("accept_wait", 32'(n < 50), 32'd1);
        step();
        req_valid = 1'b0;
        n = 1;
        while (!vld && n < 50) begin
            step();
            n++;
        end
        chk("latency", n, LAT_TAB[sel]);
        e = sb.pop_front();
        if (hold > 0) begin
            req_valid = 1'b1;
            req_wen   = 1'b0;
            req_addr  = 32'h8000_0000;
        end
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", vld, 32'd1);
            chk("hold_rdata", rdata, e.rdata);
            chk("hold_err", err, e.err);
            chk("hold_req_ready", rdy, 32'd0);
        end
        chk("rsp_rdata", rdata, e.rdata);
        chk("rsp_err", err, e.err);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("post_valid", vld, 32'd0);
        chk("post_req_ready", rdy, 32'd1);
        req_valid = 1'b0;
    endtask

    initial begin
        int          n, got, last, cyc, idx;
        logic        acc;
        exp_t        e;
        logic [31:0] words [4];

        #1 rst = 3'b111;
        step();
        chk("reset_req_ready", rdy, 32'd1);
        chk("reset_rsp_valid", vld, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_err", err, 32'd0);
        rst[0] = 1'b0;
        step();

        // Latency 2: basic write/read, byte merge, faults, empty mask, range edge, stall.
        txn(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0, 0);
        txn(1'b0, 32'h8000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0, 0);
        txn(1'b1, 32'h8000_0010, 32'h0000_AA00, 4'b0010, 32'h0, 1'b0, 0);
        txn(1'b0, 32'h8000_0010, 32'h0,         4'b0000, 32'hDEAD_AAEF, 1'b0, 0);
        txn(1'b1, 32'h8000_0000, 32'h0123_4567, 4'b1111, 32'h0, 1'b0, 0);
        txn(1'b0, 32'h7FFF_FFFC, 32'h0,         4'b0000, 32'h0, 1'b1, 0);
        txn(1'b1, 32'h8000_0002, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b1, 0);
        txn(1'b0, 32'h8000_0000, 32'h0,         4'b0000, 32'h0123_4567, 1'b0, 0);
        txn(1'b1, 32'h8000_0010, 32'h5555_5555, 4'b0000, 32'h0, 1'b0, 0);
        txn(1'b0, 32'h8000_0010, 32'h0,         4'b0000, 32'hDEAD_AAEF, 1'b0, 0);
        txn(1'b1, 32'h8000_0FFC, 32'hA5A5_0F0F, 4'b1111, 32'h0, 1'b0, 0);
        txn(1'b0, 32'h8000_0FFC, 32'h0,         4'b0000, 32'hA5A5_0F0F, 1'b0, 0);
        txn(1'b0, 32'h8000_1000, 32'h0,         4'b0000, 32'h0, 1'b1, 0);
        txn(1'b0, 32'h8000_0010, 32'h0,         4'b0000, 32'hDEAD_AAEF, 1'b0, 5);
        txn(1'b0, 32'h8000_0000, 32'h0,         4'b0000, 32'h0123_4567, 1'b0, 0);

        // Latency 1: back-to-back reads with the response always taken.
        rst[0] = 1'b1;
        sel    = 1;
        rst[1] = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            words[i] = 32'h1000_0000 + 32'(i) * 32'h1111_1111;
            txn(1'b1, 32'h8000_0040 + 32'(4 * i), words[i], 4'b1111, 32'h0, 1'b0, 0);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = 32'h8000_0040;
        idx = 0; got = 0; last = -1; cyc = 0;
        while (got < 4 && cyc < 40) begin
            acc = rdy && req_valid;
            step();
            cyc++;
            if (acc) begin
                sb.push_back('{rdata: words[idx], err: 1'b0});
                idx++;
                if (idx < 4) req_addr = 32'h8000_0040 + 32'(4 * idx);
                else         req_valid = 1'b0;
            end
            if (vld) begin
                chk("b2b_sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("b2b_rdata", rdata, e.rdata);
                    chk("b2b_err", err, e.err);
                end
                if (last >= 0) chk("b2b_gap", cyc - last, 32'd2);
                last = cyc;
                got++;
            end
        end
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("b2b_count", got, 32'd4);
        step();

        // Latency 4: reset in BUSY abandons the write.
        rst[1] = 1'b1;
        sel    = 2;
        rst[2] = 1'b0;
        step();
        txn(1'b1, 32'h8000_0020, 32'h1122_3344, 4'b1111, 32'h0, 1'b0, 0);
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = 32'h8000_0020;
        req_wdata = 32'hCAFE_F00D;
        req_wmask = 4'b1111;
        chk("abort_ready_before", rdy, 32'd1);
        step();
        req_valid = 1'b0;
        step();
        step();
        rst[2] = 1'b1;
        #1;
        chk("abort_req_ready", rdy, 32'd1);
        chk("abort_rsp_valid", vld, 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        chk("abort_err", err, 32'd0);
        step();
        rst[2] = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (vld) n++;
        end
        chk("abort_no_response", n, 32'd0);
        txn(1'b0, 32'h8000_0020, 32'h0, 4'b0000, 32'h1122_3344, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
